// File: rtl/prll_bs_pkg.sv
// Shared definitions for the parametrised single-bus round-robin arbiter.
// Contents:
//   state_t : bus controller state (IDLE, DECODE, DELIVER)
//   STATE_W : width of the exported state vector
//   id_lsb  : LSB position of the destination-ID field inside a bus word
package prll_bs_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE    = 2'd0,
        DECODE  = 2'd1,
        DELIVER = 2'd2
    } state_t;

    // The destination ID occupies the top id_w bits of each word.
    function automatic int id_lsb(input int bits, input int id_w);
        return bits - id_w;
    endfunction

endpackage

// File: rtl/prll_bs_rr_sel.sv
// Combinational round-robin selector.
// The search starts at last+1 and wraps modulo drvrs, so the most recently
// granted requester has the lowest priority.
// Ports:
//   req     [drvrs] : request vector
//   last    [lw]    : index granted most recently
//   gnt_idx [lw]    : selected index (valid only when gnt_vld)
//   gnt_vld         : at least one request is present
module prll_bs_rr_sel #(
    parameter int drvrs = 5,
    parameter int lw    = $clog2(drvrs)
) (
    input  logic [drvrs-1:0] req,
    input  logic [lw-1:0]    last,
    output logic [lw-1:0]    gnt_idx,
    output logic             gnt_vld
);

    always_comb begin
        int idx;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        idx     = 0;
        // k runs to drvrs so 'last' itself is considered as the final candidate.
        for (int k = 1; k <= drvrs; k++) begin
            idx = (int'(last) + k) % drvrs;
            if (!gnt_vld && req[idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = lw'(idx);
            end
        end
    end

endmodule

// File: rtl/prll_bs_rr_arbiter_n.sv
// Single-bus generator and round-robin arbiter for drvrs drivers.
// A word is popped from the granted source FIFO, its destination ID
// (top id_w bits) is decoded, and the word is pushed into the addressed
// sink, or into every sink except the source when the ID equals 'broadcast'.
//
// Handshake: pndng[i] means the head word on D_pop slice i is valid; a
// one-cycle pop[i] consumes it. full[i] means sink i cannot take a word;
// push[i] is only raised for sinks whose full bit was low, and a broadcast
// waits until every target sink is ready so it is delivered all at once.
//
// Ports:
//   clk, reset (asynchronous, active-low)
//   pndng [drvrs], D_pop [drvrs*bits], full [drvrs]  : FIFO status/data in
//   pop [drvrs], push [drvrs], D_push [drvrs*bits]   : FIFO strobes/data out
//   bus_busy  : a word is held waiting for delivery
//   drop_err  : one-cycle pulse when a word with a bad destination is dropped
//   state_dbg : current controller state
//   pkt_cnt [drvrs*16] : per-source delivered-word counters, present only
//                        when PRLL_BS_STATS_EN is defined
module prll_bs_rr_arbiter_n
    import prll_bs_pkg::*;
#(
    parameter int              drvrs     = 5,
    parameter int              bits      = 256,
    parameter int              id_w      = 8,
    parameter logic [id_w-1:0] broadcast = {id_w{1'b1}}
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [drvrs-1:0]        pndng,
    input  logic [drvrs*bits-1:0]   D_pop,
    input  logic [drvrs-1:0]        full,
    output logic [drvrs-1:0]        pop,
    output logic [drvrs-1:0]        push,
    output logic [drvrs*bits-1:0]   D_push,
    output logic                    bus_busy,
    output logic                    drop_err,
    output logic [STATE_W-1:0]      state_dbg
`ifdef PRLL_BS_STATS_EN
    ,
    output logic [drvrs*16-1:0]     pkt_cnt
`endif
);

    localparam int LW     = $clog2(drvrs);
    localparam int ID_LSB = id_lsb(bits, id_w);

    state_t            state_q, state_d;
    logic [bits-1:0]   data_q;
    logic [LW-1:0]     src_q, last_q;
    logic [LW-1:0]     gnt_idx;
    logic              gnt_vld;
    logic [drvrs-1:0]  mask_q, mask_d;
    logic [drvrs-1:0]  pop_d, push_d;
    logic              drop_d;
    logic              latch_en;
    logic              deliver_go;
    logic [id_w-1:0]   dst;
    logic              dst_ok;
    logic [drvrs-1:0]  bc_mask, oh_mask;

    prll_bs_rr_sel #(
        .drvrs (drvrs),
        .lw    (LW)
    ) u_sel (
        .req     (pndng),
        .last    (last_q),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    assign dst    = data_q[bits-1:ID_LSB];
    assign dst_ok = (32'(dst) < 32'(drvrs));

    always_comb begin
        bc_mask = '0;
        oh_mask = '0;
        for (int i = 0; i < drvrs; i++) begin
            bc_mask[i] = (LW'(i) != src_q);
            oh_mask[i] = (dst == id_w'(i));
        end
    end

    // Next-state and strobe logic; strobes are registered so every output
    // is glitch-free and forced low by reset.
    always_comb begin
        state_d    = state_q;
        mask_d     = mask_q;
        pop_d      = '0;
        push_d     = '0;
        drop_d     = 1'b0;
        latch_en   = 1'b0;
        deliver_go = 1'b0;
        case (state_q)
            IDLE: begin
                if (gnt_vld) begin
                    pop_d[gnt_idx] = 1'b1;
                    latch_en       = 1'b1;
                    state_d        = DECODE;
                end
            end
            DECODE: begin
                // Broadcast is tested first so it wins even if it were < drvrs.
                if (dst == broadcast) begin
                    mask_d  = bc_mask;
                    state_d = DELIVER;
                end else if (dst_ok) begin
                    mask_d  = oh_mask;
                    state_d = DELIVER;
                end else begin
                    drop_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            DELIVER: begin
                if ((full & mask_q) == '0) begin
                    push_d     = mask_q;
                    deliver_go = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q   <= '0;
            src_q    <= '0;
            last_q   <= LW'(drvrs - 1);
            mask_q   <= '0;
            pop      <= '0;
            push     <= '0;
            drop_err <= 1'b0;
        end else begin
            mask_q   <= mask_d;
            pop      <= pop_d;
            push     <= push_d;
            drop_err <= drop_d;
            if (latch_en) begin
                data_q <= D_pop[int'(gnt_idx)*bits +: bits];
                src_q  <= gnt_idx;
                last_q <= gnt_idx;
            end
        end
    end

    assign D_push    = {drvrs{data_q}};
    assign bus_busy  = (state_q == DELIVER);
    assign state_dbg = state_q;

`ifdef PRLL_BS_STATS_EN
    logic [15:0] cnt_q [drvrs];

    // Counts advance on the same edge that raises push; 16-bit wrap is natural.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < drvrs; i++) begin
                cnt_q[i] <= '0;
            end
        end else if (deliver_go) begin
            cnt_q[src_q] <= cnt_q[src_q] + 16'd1;
        end
    end

    for (genvar gi = 0; gi < drvrs; gi++) begin : g_cnt
        assign pkt_cnt[gi*16 +: 16] = cnt_q[gi];
    end
`endif

endmodule

// File: tb/tb_prll_bs_rr_arbiter_n.sv
// Self-checking bench for prll_bs_rr_arbiter_n (drvrs=5, bits=32, id_w=8).
// Source FIFOs are modelled as queues; a transaction-level model predicts the
// round-robin grant and the resulting push/drop for every popped word, and
// directed sequences pin exact cycle timing with literal expectations.
module tb_prll_bs_rr_arbiter_n;

    localparam int N = 5;
    localparam int B = 32;
    localparam int W = 41;   // {drop, src[2:0], mask[4:0], word[31:0]}

    logic               clk = 1'b0;
    logic               reset;
    logic [N-1:0]       pndng = '0;
    logic [N*B-1:0]     D_pop = '0;
    logic [N-1:0]       full;
    logic [N-1:0]       pop;
    logic [N-1:0]       push;
    logic [N*B-1:0]     D_push;
    logic               bus_busy;
    logic               drop_err;
    logic [1:0]         state_dbg;
`ifdef PRLL_BS_STATS_EN
    logic [N*16-1:0]    pkt_cnt;
    int                 m_cnt [N];
`endif

    always #5 clk = ~clk;

    prll_bs_rr_arbiter_n #(
        .drvrs (N),
        .bits  (B),
        .id_w  (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .pndng     (pndng),
        .D_pop     (D_pop),
        .full      (full),
        .pop       (pop),
        .push      (push),
        .D_push    (D_push),
        .bus_busy  (bus_busy),
        .drop_err  (drop_err),
        .state_dbg (state_dbg)
`ifdef PRLL_BS_STATS_EN
        ,
        .pkt_cnt   (pkt_cnt)
`endif
    );

    logic [B-1:0] fq [N][$];
    logic [W-1:0] exp_q [$];
    int           gnt_log [$];
    int           m_last = N - 1;
    int           n_cmp  = 0;
    int           n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic load(input int d, input logic [B-1:0] w);
        fq[d].push_back(w);
    endtask

    function automatic int fq_total();
        int s = 0;
        for (int i = 0; i < N; i++) s += fq[i].size();
        return s;
    endfunction

    // First requester after 'last', wrapping around.
    function automatic int rr_pick(input int last, input logic [N-1:0] req);
        int r = -1;
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (last + k) % N;
            if (r < 0 && req[i]) r = i;
        end
        return r;
    endfunction

    function automatic int onehot_idx(input logic [N-1:0] v);
        int r = -1;
        if ($countones(v) == 1) begin
            for (int i = 0; i < N; i++) if (v[i]) r = i;
        end
        return r;
    endfunction

    // FIFO heads presented to the DUT, refreshed just after each falling edge.
    always @(negedge clk) begin
        #1;
        for (int i = 0; i < N; i++) begin
            pndng[i]       = (fq[i].size() != 0);
            D_pop[i*B +: B] = (fq[i].size() != 0) ? fq[i][0] : '0;
        end
    end

    // Model and per-cycle comparison.
    always @(posedge clk) begin
        int           g;
        logic [N-1:0] exp_pop;
        logic [N-1:0] mask;
        logic [B-1:0] w;
        logic [7:0]   dst;
        logic         drop;
        logic [W-1:0] e;
        #1;
        if (!reset) begin
            exp_q.delete();
            m_last = N - 1;
`ifdef PRLL_BS_STATS_EN
            for (int i = 0; i < N; i++) m_cnt[i] = 0;
`endif
        end else begin
            if (pop != '0) begin
                g = rr_pick(m_last, pndng);
                exp_pop = '0;
                if (g >= 0) exp_pop[g] = 1'b1;
                check("pop_grant", 64'(pop), 64'(exp_pop));
                gnt_log.push_back(onehot_idx(pop));
                if (g >= 0 && fq[g].size() > 0) begin
                    w      = fq[g].pop_front();
                    m_last = g;
                    dst    = w[31:24];
                    drop   = 1'b0;
                    mask   = '0;
                    if (dst == 8'hFF) begin
                        mask    = 5'h1F;
                        mask[g] = 1'b0;
                    end else if (dst < 8'd5) begin
                        mask[dst[2:0]] = 1'b1;
                    end else begin
                        drop = 1'b1;
                    end
                    exp_q.push_back({drop, 3'(g), mask, w});
                end
            end
            if (push != '0 || drop_err) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_out: push=%b drop_err=%b with nothing in flight", push, drop_err);
                end else begin
                    e = exp_q.pop_front();
                    check("push_mask", 64'(push), 64'(e[36:32]));
                    check("drop_err", 64'(drop_err), 64'(e[40]));
                    if (!e[40]) begin
                        for (int i = 0; i < N; i++) check("D_push_slice", 64'(D_push[i*B +: B]), 64'(e[31:0]));
`ifdef PRLL_BS_STATS_EN
                        m_cnt[e[39:37]]++;
`endif
                    end
                end
            end
`ifdef PRLL_BS_STATS_EN
            for (int i = 0; i < N; i++) check("pkt_cnt", 64'(pkt_cnt[i*16 +: 16]), 64'(m_cnt[i] % 65536));
`endif
        end
    end

    task automatic drain(input int max);
        int t = 0;
        while ((fq_total() != 0 || exp_q.size() != 0 || state_dbg != 2'd0 || push != '0) && t < max) begin
            @(negedge clk);
            t++;
        end
        n_cmp++;
        if (t >= max) begin
            n_fail++;
            $display("FAIL drain_timeout: %0d words queued, %0d in flight after %0d cycles", fq_total(), exp_q.size(), t);
        end
    endtask

    initial begin
        bit got;
        reset = 1'b0;
        full  = '0;
        repeat (3) @(negedge clk);
        check("rst_pop", 64'(pop), 64'd0);
        check("rst_push", 64'(push), 64'd0);
        check("rst_dpush", 64'(|D_push), 64'd0);
        check("rst_busy", 64'(bus_busy), 64'd0);
        check("rst_drop", 64'(drop_err), 64'd0);
        check("rst_state", 64'(state_dbg), 64'd0);
        reset = 1'b1;
        @(negedge clk);

        // Single unicast: driver 2 -> sink 4, exact latency.
        load(2, 32'h04A5A5A5);
        @(negedge clk);
        check("t1_pop", 64'(pop), 64'b00100);
        check("t1_busy_decode", 64'(bus_busy), 64'd0);
        @(negedge clk);
        check("t1_busy_deliver", 64'(bus_busy), 64'd1);
        check("t1_no_push_yet", 64'(push), 64'd0);
        @(negedge clk);
        check("t1_push", 64'(push), 64'b10000);
        check("t1_dpush4", 64'(D_push[4*B +: B]), 64'h04A5A5A5);
        check("t1_busy_after", 64'(bus_busy), 64'd0);
        drain(20);

        // All drivers loaded: grant order must rotate 0..4 without skips.
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        gnt_log.delete();
        for (int d = 0; d < N; d++)
            for (int k = 0; k < 10; k++) load(d, {8'h00, 8'(d), 16'(k)});
        drain(400);
        check("t2_grant_count", 64'(gnt_log.size()), 64'd50);
        for (int k = 0; k < gnt_log.size(); k++) check("t2_grant_order", 64'(gnt_log[k]), 64'(k % 5));

        // Broadcast from driver 1.
        load(1, 32'hFF123456);
        got = 1'b0;
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk);
            if (push != '0) got = 1'b1;
        end
        check("t3_bcast_push", 64'(push), 64'b11101);
        @(negedge clk);
        check("t3_single_cycle", 64'(push), 64'd0);
        drain(20);

        // Back-pressure: sink 0 full for 7 cycles.
        full = 5'b00001;
        load(3, 32'h00333333);
        @(negedge clk);
        check("t4_pop", 64'(pop), 64'b01000);
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            check("t4_busy_hold", 64'(bus_busy), 64'd1);
            check("t4_no_push", 64'(push), 64'd0);
        end
        full = '0;
        @(negedge clk);
        check("t4_push", 64'(push), 64'b00001);
        drain(20);

        // Bad destination 0x07 is dropped; next word still flows.
        load(0, 32'h07777777);
        @(negedge clk);
        check("t5_pop", 64'(pop), 64'b00001);
        @(negedge clk);
        check("t5_drop", 64'(drop_err), 64'd1);
        check("t5_no_push", 64'(push), 64'd0);
        check("t5_not_busy", 64'(bus_busy), 64'd0);
        load(4, 32'h01444444);
        @(negedge clk);
        check("t5_drop_pulse", 64'(drop_err), 64'd0);
        check("t5_next_pop", 64'(pop), 64'b10000);
        drain(20);

        // Reset while a word is held in DELIVER.
        full = 5'b01000;
        load(2, 32'h03222222);
        @(negedge clk);
        check("t6_pop", 64'(pop), 64'b00100);
        @(negedge clk);
        check("t6_busy", 64'(bus_busy), 64'd1);
        @(negedge clk);
        check("t6_still_busy", 64'(bus_busy), 64'd1);
        reset = 1'b0;
        #1;
        check("t6_rst_busy", 64'(bus_busy), 64'd0);
        check("t6_rst_push", 64'(push), 64'd0);
        check("t6_rst_pop", 64'(pop), 64'd0);
        check("t6_rst_dpush", 64'(|D_push), 64'd0);
        check("t6_rst_state", 64'(state_dbg), 64'd0);
`ifdef PRLL_BS_STATS_EN
        check("t6_rst_cnt", 64'(|pkt_cnt), 64'd0);
`endif
        full = '0;
        load(3, 32'h01333333);
        load(0, 32'h02000000);
        @(negedge clk);
        check("t6_rst_no_push", 64'(push), 64'd0);
        reset = 1'b1;
        @(negedge clk);
        check("t6_first_grant", 64'(pop), 64'b00001);
        drain(40);

        check("final_inflight", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
